// File: rtl/stream_hsmooth.sv
// Avalon-ST video stage: 3-tap [1 2 1]/4 horizontal smoothing of RGB pixels in video packets.
// Optional STREAM_HSMOOTH_MODE_EN adds a 'mode' input; mode=0 bypasses the filter per pixel.
module stream_hsmooth #(
  parameter logic [10:0] IMAGE_W    = 11'd640,
  parameter int unsigned DATA_WIDTH = 24
) (
`ifdef STREAM_HSMOOTH_MODE_EN
  input  logic                  mode,
`endif
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] sink_data,
  input  logic                  sink_valid,
  output logic                  sink_ready,
  input  logic                  sink_sop,
  input  logic                  sink_eop,
  output logic [DATA_WIDTH-1:0] source_data,
  output logic                  source_valid,
  input  logic                  source_ready,
  output logic                  source_sop,
  output logic                  source_eop,
  output logic [15:0]           frame_count
);

  localparam int unsigned XW = 11;
  localparam int unsigned CW = 8;
  localparam int unsigned FW = 16;

  typedef enum logic [2:0] {IDLE, PASS, FILL, RUN, DRAIN} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] l_q;
  logic [DATA_WIDTH-1:0] c_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_valid_q;
  logic                  out_sop_q;
  logic                  out_eop_q;
  logic [XW-1:0]         x_q;
  logic [FW-1:0]         frame_q;

  logic                  at_edge;
  logic                  out_free;
  logic                  accept;
  logic                  filt_en;
  logic [DATA_WIDTH-1:0] r_pix;
  logic [DATA_WIDTH-1:0] run_pix_d;
  logic [DATA_WIDTH-1:0] drain_pix_d;

  // One channel of (L + 2C + R + 2) >> 2; 10 bits cannot overflow for 8-bit inputs.
  function automatic logic [CW-1:0] tap3(input logic [CW-1:0] l, input logic [CW-1:0] c,
                                         input logic [CW-1:0] r);
    logic [9:0] sum;
    sum = 10'(l) + 10'({c, 1'b0}) + 10'(r) + 10'd2;
    return sum[9:2];
  endfunction

  function automatic logic [23:0] filt(input logic [23:0] l, input logic [23:0] c,
                                       input logic [23:0] r);
    return {tap3(l[23:16], c[23:16], r[23:16]),
            tap3(l[15:8],  c[15:8],  r[15:8]),
            tap3(l[7:0],   c[7:0],   r[7:0])};
  endfunction

`ifdef STREAM_HSMOOTH_MODE_EN
  assign filt_en = mode;
`else
  assign filt_en = 1'b1;
`endif

  // Right neighbour is replicated when the held pixel closes a line.
  assign at_edge     = (x_q == IMAGE_W - 11'd1);
  assign r_pix       = at_edge ? c_q : sink_data;
  assign run_pix_d   = filt_en ? filt(l_q, c_q, r_pix) : c_q;
  assign drain_pix_d = filt_en ? filt(l_q, c_q, c_q) : c_q;

  assign out_free   = ~out_valid_q | source_ready;
  assign sink_ready = out_free & (state_q != DRAIN);
  assign accept     = sink_valid & sink_ready;

  assign source_data  = out_data_q;
  assign source_valid = out_valid_q;
  assign source_sop   = out_sop_q;
  assign source_eop   = out_eop_q;
  assign frame_count  = frame_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      l_q         <= '0;
      c_q         <= '0;
      x_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      frame_q     <= '0;
    end else begin
      if (source_ready) out_valid_q <= 1'b0;
      if (accept) begin
        if (sink_sop) begin
          // Any sop restarts packet parsing; a pending pixel is silently dropped.
          out_valid_q <= 1'b1;
          out_data_q  <= sink_data;
          out_sop_q   <= 1'b1;
          out_eop_q   <= sink_eop;
          x_q         <= '0;
          if (sink_eop)                  state_q <= IDLE;
          else if (sink_data[3:0] == 4'h0) state_q <= FILL;
          else                           state_q <= PASS;
        end else begin
          case (state_q)
            FILL: begin
              l_q     <= sink_data;
              c_q     <= sink_data;
              x_q     <= '0;
              state_q <= sink_eop ? DRAIN : RUN;
            end
            RUN: begin
              out_valid_q <= 1'b1;
              out_data_q  <= run_pix_d;
              out_sop_q   <= 1'b0;
              out_eop_q   <= 1'b0;
              c_q         <= sink_data;
              if (at_edge) begin
                l_q <= sink_data;
                x_q <= '0;
              end else begin
                l_q <= c_q;
                x_q <= x_q + 11'd1;
              end
              if (sink_eop) state_q <= DRAIN;
            end
            default: begin
              out_valid_q <= 1'b1;
              out_data_q  <= sink_data;
              out_sop_q   <= 1'b0;
              out_eop_q   <= sink_eop;
              if (sink_eop) state_q <= IDLE;
            end
          endcase
        end
      end else if (state_q == DRAIN && out_free) begin
        out_valid_q <= 1'b1;
        out_data_q  <= drain_pix_d;
        out_sop_q   <= 1'b0;
        out_eop_q   <= 1'b1;
        frame_q     <= frame_q + 16'd1;
        state_q     <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_stream_hsmooth.sv
// Directed bench for stream_hsmooth with IMAGE_W=4; output words are collected and compared
// against hand-computed streams.
module tb_stream_hsmooth;

  logic        clk;
  logic        reset;
  logic [23:0] sink_data;
  logic        sink_valid;
  logic        sink_ready;
  logic        sink_sop;
  logic        sink_eop;
  logic [23:0] source_data;
  logic        source_valid;
  logic        source_ready;
  logic        source_sop;
  logic        source_eop;
  logic [15:0] frame_count;
`ifdef STREAM_HSMOOTH_MODE_EN
  logic        mode;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [25:0] mon_q[$];
  logic [25:0] exp_q[$];

  stream_hsmooth #(.IMAGE_W(11'd4), .DATA_WIDTH(24)) dut (
`ifdef STREAM_HSMOOTH_MODE_EN
    .mode        (mode),
`endif
    .clk         (clk),
    .reset       (reset),
    .sink_data   (sink_data),
    .sink_valid  (sink_valid),
    .sink_ready  (sink_ready),
    .sink_sop    (sink_sop),
    .sink_eop    (sink_eop),
    .source_data (source_data),
    .source_valid(source_valid),
    .source_ready(source_ready),
    .source_sop  (source_sop),
    .source_eop  (source_eop),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1);
  end

  // Record every output transfer as {sop, eop, data}.
  always begin
    @(negedge clk);
    #1;
    if (!reset && source_valid && source_ready)
      mon_q.push_back({source_sop, source_eop, source_data});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] g(input logic [7:0] v);
    return {v, v, v};
  endfunction

  task automatic expw(input logic s, input logic e, input logic [23:0] d);
    exp_q.push_back({s, e, d});
  endtask

  task automatic send(input logic [23:0] d, input logic s, input logic e);
    int n;
    n = 0;
    @(negedge clk);
    sink_data  = d;
    sink_valid = 1'b1;
    sink_sop   = s;
    sink_eop   = e;
    #1;
    while (!sink_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("send_timeout", 32'(sink_ready), 32'd1);
    @(posedge clk);
  endtask

  task automatic sink_idle();
    @(negedge clk);
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
  endtask

  task automatic check_stream(input string tag);
    int n;
    n = 0;
    while (mon_q.size() < exp_q.size() && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_len"}, 32'(mon_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < mon_q.size())
        chk($sformatf("%s_w%0d", tag, i), 32'(mon_q[i]), 32'(exp_q[i]));
    mon_q.delete();
    exp_q.delete();
  endtask

  initial begin
    reset        = 1'b1;
    sink_data    = '0;
    sink_valid   = 1'b0;
    sink_sop     = 1'b0;
    sink_eop     = 1'b0;
    source_ready = 1'b1;
`ifdef STREAM_HSMOOTH_MODE_EN
    mode         = 1'b1;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_valid", 32'(source_valid), 32'd0);
    chk("rst_data",  32'(source_data),  32'd0);
    chk("rst_sop",   32'(source_sop),   32'd0);
    chk("rst_eop",   32'(source_eop),   32'd0);
    chk("rst_fc",    32'(frame_count),  32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ready", 32'(sink_ready), 32'd1);

    // Two-line video frame, R ramp 0,4,8,12 per line.
    send(24'h000000, 1'b1, 1'b0);
    for (int ln = 0; ln < 2; ln++)
      for (int i = 0; i < 4; i++)
        send({8'(i * 4), 16'h0000}, 1'b0, (ln == 1 && i == 3));
    sink_idle();
    expw(1'b1, 1'b0, 24'h000000);
    for (int ln = 0; ln < 2; ln++) begin
      expw(1'b0, 1'b0, 24'h010000);
      expw(1'b0, 1'b0, 24'h040000);
      expw(1'b0, 1'b0, 24'h080000);
      expw(1'b0, (ln == 1), 24'h0B0000);
    end
    check_stream("vid");
    chk("vid_fc", 32'(frame_count), 32'd1);

    // Non-video packet passes through bit-exact.
    send(24'h00000F, 1'b1, 1'b0);
    send(24'h123456, 1'b0, 1'b0);
    send(24'h123456, 1'b0, 1'b0);
    send(24'h123456, 1'b0, 1'b1);
    sink_idle();
    expw(1'b1, 1'b0, 24'h00000F);
    expw(1'b0, 1'b0, 24'h123456);
    expw(1'b0, 1'b0, 24'h123456);
    expw(1'b0, 1'b1, 24'h123456);
    check_stream("pass");
    chk("pass_fc", 32'(frame_count), 32'd1);

    // Single-word packet carrying sop and eop.
    send(24'h000000, 1'b1, 1'b1);
    sink_idle();
    expw(1'b1, 1'b1, 24'h000000);
    check_stream("sopeop");
    chk("sopeop_fc", 32'(frame_count), 32'd1);

    // Saturated white line must not overflow.
    send(24'h000000, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send(24'hFFFFFF, 1'b0, (i == 3));
    sink_idle();
    expw(1'b1, 1'b0, 24'h000000);
    for (int i = 0; i < 4; i++) expw(1'b0, (i == 3), 24'hFFFFFF);
    check_stream("white");
    chk("white_fc", 32'(frame_count), 32'd2);

    // Downstream stall of 5 cycles while the source keeps offering pixels.
    fork
      begin
        send(24'h000000, 1'b1, 1'b0);
        send(g(8'd10), 1'b0, 1'b0);
        send(g(8'd20), 1'b0, 1'b0);
        send(g(8'd30), 1'b0, 1'b0);
        send(g(8'd40), 1'b0, 1'b1);
        sink_idle();
      end
      begin
        repeat (4) @(negedge clk);
        source_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          #1;
          chk("stall_ready", 32'(sink_ready),   32'd0);
          chk("stall_valid", 32'(source_valid), 32'd1);
          chk("stall_data",  32'(source_data),  32'h0D0D0D);
          @(negedge clk);
        end
        source_ready = 1'b1;
      end
    join
    expw(1'b1, 1'b0, 24'h000000);
    expw(1'b0, 1'b0, 24'h0D0D0D);
    expw(1'b0, 1'b0, 24'h141414);
    expw(1'b0, 1'b0, 24'h1E1E1E);
    expw(1'b0, 1'b1, 24'h262626);
    check_stream("stall");
    chk("stall_fc", 32'(frame_count), 32'd3);

    // New sop after 3 pixels aborts the frame without an eop.
    send(24'h000000, 1'b1, 1'b0);
    send(g(8'd10), 1'b0, 1'b0);
    send(g(8'd20), 1'b0, 1'b0);
    send(g(8'd30), 1'b0, 1'b0);
    send(24'h000000, 1'b1, 1'b0);
    send(g(8'd10), 1'b0, 1'b0);
    send(g(8'd20), 1'b0, 1'b0);
    send(g(8'd30), 1'b0, 1'b0);
    send(g(8'd40), 1'b0, 1'b1);
    sink_idle();
    expw(1'b1, 1'b0, 24'h000000);
    expw(1'b0, 1'b0, 24'h0D0D0D);
    expw(1'b0, 1'b0, 24'h141414);
    expw(1'b1, 1'b0, 24'h000000);
    expw(1'b0, 1'b0, 24'h0D0D0D);
    expw(1'b0, 1'b0, 24'h141414);
    expw(1'b0, 1'b0, 24'h1E1E1E);
    expw(1'b0, 1'b1, 24'h262626);
    check_stream("abort");
    chk("abort_fc", 32'(frame_count), 32'd4);

    // One-cycle reset while in RUN, then a clean frame.
    send(24'h000000, 1'b1, 1'b0);
    send(g(8'd10), 1'b0, 1'b0);
    send(g(8'd20), 1'b0, 1'b0);
    @(negedge clk);
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
    reset      = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rrun_valid", 32'(source_valid), 32'd0);
    chk("rrun_fc",    32'(frame_count),  32'd0);
    mon_q.delete();
    send(24'h000000, 1'b1, 1'b0);
    send(g(8'd10), 1'b0, 1'b0);
    send(g(8'd20), 1'b0, 1'b0);
    send(g(8'd30), 1'b0, 1'b0);
    send(g(8'd40), 1'b0, 1'b1);
    sink_idle();
    expw(1'b1, 1'b0, 24'h000000);
    expw(1'b0, 1'b0, 24'h0D0D0D);
    expw(1'b0, 1'b0, 24'h141414);
    expw(1'b0, 1'b0, 24'h1E1E1E);
    expw(1'b0, 1'b1, 24'h262626);
    check_stream("rrun");
    chk("rrun_fc2", 32'(frame_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
